// File: rtl/ins_loader_if.sv
// ins_loader_if: byte-stream input and instruction-memory write bus of the
// program loader.
//   in_data/in_valid/in_ready : framed byte stream, transfer when valid & ready
//   mem_we/mem_addr/mem_wdata : one-cycle word write strobe into instruction memory
// Modports: master = stream producer / memory observer, slave = the loader.
interface ins_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/ins_loader.sv
// ins_loader: boot-time program loader in front of the core's instruction
// memory. Takes a frame {CNT_LO, CNT_HI, 4*N payload bytes, CSUM} over a
// valid/ready byte stream, assembles little-endian 32-bit words, writes them
// at byte addresses 0, 4, 8, ... and keeps the core in reset until a frame
// with a matching XOR checksum has been loaded.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle pulse starting a load (honoured in IDLE/DONE/ERROR)
//   bus       : byte stream in, memory write strobe out (ins_loader_if.slave)
//   cpu_rst   : core reset, low only in DONE
//   done      : load finished with a good checksum
//   error     : load aborted (oversize frame or bad checksum)
module ins_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  ins_loader_if.slave bus,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [16:0]       word_cnt_q, word_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              in_ready;
  logic              xfer;
  logic [15:0]       hdr_n;
  logic [16:0]       word_cnt_inc;

  always_comb begin
    in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
               (state_q == S_DATA) || (state_q == S_CSUM);
  end

  assign xfer         = bus.in_valid && in_ready;
  assign hdr_n        = {bus.in_data, cnt_lo_q};
  assign word_cnt_inc = word_cnt_q + 17'd1;

  always_comb begin
    state_d     = state_q;
    cnt_lo_d    = cnt_lo_q;
    cnt_d       = cnt_q;
    word_cnt_d  = word_cnt_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cnt_lo_d   = '0;
          cnt_d      = '0;
          word_cnt_d = '0;
          idx_d      = '0;
          asm_d      = '0;
          csum_d     = '0;
          mem_addr_d = '0;
        end
      end

      S_HDR0: begin
        if (xfer) begin
          cnt_lo_d = bus.in_data;
          state_d  = S_HDR1;
        end
      end

      S_HDR1: begin
        if (xfer) begin
          cnt_d = hdr_n;
          if (32'(hdr_n) > DEPTH_WORDS) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (hdr_n == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ bus.in_data;
          idx_d  = idx_q + 2'd1;
          case (idx_q)
            2'd0: asm_d[7:0]   = bus.in_data;
            2'd1: asm_d[15:8]  = bus.in_data;
            2'd2: asm_d[23:16] = bus.in_data;
            default: begin
              // Lane 3 goes straight into the write register, so the word is
              // presented on the next cycle while in_ready stays high.
              mem_we_d    = 1'b1;
              mem_wdata_d = {bus.in_data, asm_q};
              mem_addr_d  = ADDR_W'({word_cnt_q, 2'b00});
              word_cnt_d  = word_cnt_inc;
              if (word_cnt_inc == {1'b0, cnt_q}) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end

      S_CSUM: begin
        if (xfer) begin
          if (bus.in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_lo_q    <= '0;
      cnt_q       <= '0;
      word_cnt_q  <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      cnt_q       <= cnt_d;
      word_cnt_q  <= word_cnt_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Decoded from the state register so it follows rst asynchronously.
  assign cpu_rst = (state_q != S_DONE);
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_ins_loader.sv
module tb_ins_loader;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst;
  logic start;
  logic cpu_rst;
  logic done;
  logic error;

  ins_loader_if #(.ADDR_W(32)) bus ();

  ins_loader #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus),
    .cpu_rst(cpu_rst),
    .done(done),
    .error(error)
  );

  int unsigned ntests = 0;
  int unsigned nfail  = 0;
  wr_t exp_q[$];
  logic prev_we = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops the next expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_we = 1'b0;
      end else begin
        if (prev_we) check("we_single_cycle", 64'(bus.mem_we), 64'd0);
        if (bus.mem_we === 1'b1) begin
          if (exp_q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     bus.mem_addr, bus.mem_wdata);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
            check("wr_data", 64'(bus.mem_wdata), 64'(e.data));
          end
        end
        prev_we = bus.mem_we;
      end
    end
  end

  // Reference model: parses a frame, queues the writes it implies and
  // returns the outcome and how many bytes the loader will consume.
  function automatic void model(input logic [7:0] fr[$], output bit ok,
                                output int unsigned nsend);
    int unsigned n;
    logic [7:0]  x;
    wr_t         e;
    n = 32'({fr[1], fr[0]});
    x = 8'h00;
    if (n > DEPTH) begin
      ok    = 1'b0;
      nsend = 2;
      return;
    end
    for (int unsigned w = 0; w < n; w++) begin
      e.addr = 32'(w * 4);
      e.data = {fr[2+4*w+3], fr[2+4*w+2], fr[2+4*w+1], fr[2+4*w]};
      exp_q.push_back(e);
      for (int unsigned b = 0; b < 4; b++) x ^= fr[2+4*w+b];
    end
    ok    = (fr[2+4*n] == x);
    nsend = 3 + 4 * n;
  endfunction

  task automatic make_frame(input int unsigned n, input bit bad, output logic [7:0] fr[$]);
    logic [7:0] x;
    logic [7:0] b;
    logic [15:0] n16;
    n16 = 16'(n);
    fr = {};
    fr.push_back(n16[7:0]);
    fr.push_back(n16[15:8]);
    x = 8'h00;
    if (n <= DEPTH) begin
      for (int unsigned i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x ^= b;
        fr.push_back(b);
      end
      if (bad) fr.push_back(x ^ 8'($urandom_range(1, 255)));
      else     fr.push_back(x);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output int unsigned waits);
    logic rdy;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        start        = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    waits = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        check("byte_accept_timeout", 64'(waits), 64'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] fr[$], input bit gaps);
    bit ok;
    int unsigned nsend;
    int unsigned waits;
    model(fr, ok, nsend);
    // Bytes offered while not ready must be left unconsumed.
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    do_start();
    for (int unsigned i = 0; i < nsend; i++) begin
      send_byte(fr[i], gaps, waits);
      if (!gaps) check("no_stall", 64'(waits), 64'd0);
    end
    @(negedge clk);
    check("done", 64'(done), 64'(ok));
    check("error", 64'(error), 64'(!ok));
    check("cpu_rst", 64'(cpu_rst), 64'(!ok));
    check("end_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("writes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] pay[$];
    int unsigned waits;

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // XOR of this payload is 0x2A; 0xCC and 0x00 are both bad checksums.
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    run_frame(fr, 1'b0);

    // Reset out of DONE must raise cpu_rst without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_cpu_rst", 64'(cpu_rst), 64'd1);
    check("async_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    run_frame(fr, 1'b0);
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hCC};
    run_frame(fr, 1'b0);

    fr = '{8'h01, 8'h01};
    run_frame(fr, 1'b0);

    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(fr, 1'b0);
    fr = '{8'h00, 8'h00, 8'h01};
    run_frame(fr, 1'b0);

    // Three words back to back, then the same frame with random valid gaps.
    make_frame(3, 1'b0, fr);
    pay = fr;
    run_frame(pay, 1'b0);
    run_frame(pay, 1'b1);

    make_frame(DEPTH, 1'b0, fr);
    run_frame(fr, 1'b0);

    // Reset after two payload bytes: no write, clean reload from address 0.
    do_start();
    send_byte(8'h03, 1'b0, waits);
    send_byte(8'h00, 1'b0, waits);
    send_byte(8'h11, 1'b0, waits);
    send_byte(8'h22, 1'b0, waits);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    run_frame(fr, 1'b0);

    for (int unsigned t = 0; t < 10; t++) begin
      make_frame($urandom_range(0, 6), ($urandom_range(0, 1) == 1), fr);
      run_frame(fr, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, failed so far %0d", nfail);
    $fatal(1, "timeout");
  end

endmodule
